adder_arbiter: RTL

//  Shares one full_adder_32bit between NUM_REQ requesters (e.g. PC+4, branch target, ALU, LSU address).

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_arbiter_rr_arbiter.sv | 34 +++
 rtl/full_adder_32bit.sv | 12 +
 rtl/adder_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the shared-adder arbitration block.
// The result register is modelled as a two-state EMPTY/FULL machine.
package adder_pkg;

  localparam int   ADDER_W = 32;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam int   MAX_REQ = 8;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [ADDER_W-1:0] sum;
    logic               c_out;
    logic               ovf;
  } add_res_t;

  // Two's-complement overflow from the effective operand signs and the result sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  always_comb begin : pick
    logic [ID_W:0] cand;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr+k can be folded back below NUM_REQ for any count.
      cand = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!any_o && req_i[cand[ID_W-1:0]]) begin
        any_o                      = 1'b1;
        grant_o[cand[ID_W-1:0]]    = 1'b1;
        grant_idx_o                = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry in/out, shared by all requesters.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one 32-bit adder between NUM_REQ requesters, with a
// single registered result stage that sustains one operation per cycle.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDER_W-1:0] req_a,
  input  logic [NUM_REQ*ADDER_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [ADDER_W-1:0]         rsp_sum,
  output logic                       rsp_c_out,
  output logic                       rsp_ovf
);

  rsp_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  add_res_t           res_q, res_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept_en;
  logic               fire;

  logic [ADDER_W-1:0] a_sel, b_sel, b_eff, add_sum;
  logic               sub_sel, add_c_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Reset also masks ready so nothing appears accepted while the block is held.
  assign accept_en = (state_q == RSP_EMPTY) || rsp_ready;
  assign req_ready = grant & {NUM_REQ{accept_en & rst_n}};
  assign fire      = accept_en & grant_any;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[ADDER_W*i +: ADDER_W];
        b_sel   = req_b[ADDER_W*i +: ADDER_W];
        sub_sel = req_sub[i];
      end
    end
  end

  assign b_eff = (sub_sel == OP_SUB) ? ~b_sel : b_sel;

  full_adder_32bit u_adder (
    .a     (a_sel),
    .b     (b_eff),
    .c_in  (sub_sel),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    res_d   = res_q;
    if (fire) begin
      state_d     = RSP_FULL;
      id_d        = grant_idx;
      res_d.sum   = add_sum;
      res_d.c_out = add_c_out;
      res_d.ovf   = signed_ovf(a_sel[ADDER_W-1], b_eff[ADDER_W-1], add_sum[ADDER_W-1]);
      ptr_d       = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    end else if ((state_q == RSP_FULL) && rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
      id_q    <= '0;
      ptr_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = res_q.sum;
  assign rsp_c_out = res_q.c_out;
  assign rsp_ovf   = res_q.ovf;

endmodule
